// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum accumulator slice.
package sum_acc_pkg;

  localparam int ADDER_W   = 16;
  localparam int SAMPLE_W  = 17;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Control, sample and result handshake bundle between the adder side and the accumulator.
interface sum_accumulator_if
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic [ADDER_W-1:0] in_sum;
  logic               in_carry;
  logic               in_valid;
  logic               in_ready;
  logic [ACC_W-1:0]   acc_out;
  logic               overflow;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output start, num_samples, in_sum, in_carry, in_valid, out_ready,
    input  in_ready, acc_out, overflow, out_valid, busy
  );

  modport slave (
    input  start, num_samples, in_sum, in_carry, in_valid, out_ready,
    output in_ready, acc_out, overflow, out_valid, busy
  );
endinterface

// File: rtl/acc_add_sat.sv
// ACC_W+1-bit accumulate adder with overflow flag.
// With SUM_ACC_SATURATE_EN defined the result clamps to all-ones on overflow, otherwise it wraps.
module acc_add_sat #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] sample,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] wide_sum;

  assign wide_sum = {1'b0, acc} + {1'b0, sample};
  assign ovf      = wide_sum[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
  // Once clamped, any further non-zero sample overflows again, so the clamp holds for the run.
  assign sum = ovf ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
  assign sum = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of 17-bit adder results and presents the total via valid/ready.
// Optional saturation on overflow is enabled with SUM_ACC_SATURATE_EN (see acc_add_sat).
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  sum_accumulator_if.slave bus
);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     remaining_reg;
  logic [ACC_W-1:0]     acc_reg;
  logic                 overflow_reg;

  logic [SAMPLE_W-1:0]  sample_raw;
  logic [ACC_W-1:0]     sample_ext;
  logic [ACC_W-1:0]     add_sum;
  logic                 add_ovf;
  logic                 accept;
  logic                 last_accept;

  assign sample_raw  = {bus.in_carry, bus.in_sum};
  assign sample_ext  = ACC_W'(sample_raw);
  assign accept      = (state_reg == ACCUM) && bus.in_valid;
  assign last_accept = accept && (remaining_reg == CNT_W'(1));

  acc_add_sat #(.ACC_W(ACC_W)) u_add (
    .acc    (acc_reg),
    .sample (sample_ext),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.num_samples == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (last_accept) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: acc_out keeps its value through DONE and back into IDLE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      overflow_reg  <= 1'b0;
      remaining_reg <= '0;
    end else begin
      if (state_reg == IDLE && bus.start) begin
        acc_reg       <= '0;
        overflow_reg  <= 1'b0;
        remaining_reg <= bus.num_samples;
      end else if (accept) begin
        acc_reg       <= add_sum;
        remaining_reg <= remaining_reg - CNT_W'(1);
        if (add_ovf) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.acc_out  = acc_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench: a 24-bit accumulator for the main runs and a 17-bit one for overflow.
// Expected overflow result depends on SUM_ACC_SATURATE_EN.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

`ifdef SUM_ACC_SATURATE_EN
  localparam int OVF_EXP = 131071;
`else
  localparam int OVF_EXP = 131070;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.ACC_W(24), .CNT_W(8)) bus_a ();
  sum_accumulator_if #(.ACC_W(17), .CNT_W(8)) bus_b ();

  sum_accumulator #(.ACC_W(24), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  sum_accumulator #(.ACC_W(17), .CNT_W(8)) u_dut17 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int n);
    bus_a.num_samples = 8'(n);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic feed_a(input logic [15:0] s, input logic c);
    bus_a.in_sum = s;
    bus_a.in_carry = c;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
  endtask

  task automatic finish_a();
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  task automatic feed_b(input logic [15:0] s, input logic c);
    bus_b.in_sum = s;
    bus_b.in_carry = c;
    bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.num_samples = '0; bus_a.in_sum = '0; bus_a.in_carry = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.num_samples = '0; bus_b.in_sum = '0; bus_b.in_carry = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_acc", 32'(bus_a.acc_out), 0);
    chk("rst_ovf", 32'(bus_a.overflow), 0);
    chk("rst_valid", 32'(bus_a.out_valid), 0);
    chk("rst_in_ready", 32'(bus_a.in_ready), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_b_acc", 32'(bus_b.acc_out), 0);
    rst_n = 1'b1;
    tick();
    $display("reset: acc=%0d busy=%0d", bus_a.acc_out, bus_a.busy);

    // Single run of two samples
    start_a(2);
    chk("t1_busy", 32'(bus_a.busy), 1);
    chk("t1_in_ready", 32'(bus_a.in_ready), 1);
    feed_a(16'd1119, 1'b0);
    chk("t1_mid_valid", 32'(bus_a.out_valid), 0);
    chk("t1_mid_acc", 32'(bus_a.acc_out), 1119);
    feed_a(16'd310, 1'b0);
    chk("t1_valid", 32'(bus_a.out_valid), 1);
    chk("t1_acc", 32'(bus_a.acc_out), 1429);
    chk("t1_ovf", 32'(bus_a.overflow), 0);
    chk("t1_done_in_ready", 32'(bus_a.in_ready), 0);
    $display("single run: acc=%0d ovf=%0d", bus_a.acc_out, bus_a.overflow);
    finish_a();
    chk("t1_valid_drop", 32'(bus_a.out_valid), 0);

    // Carry-out as bit 16
    start_a(1);
    feed_a(16'd0, 1'b1);
    chk("t2_valid", 32'(bus_a.out_valid), 1);
    chk("t2_acc", 32'(bus_a.acc_out), 65536);
    $display("carry run: acc=%0d", bus_a.acc_out);
    finish_a();

    // Stalls between samples, then backpressure on the result
    start_a(3);
    for (int i = 0; i < 3; i++) begin
      feed_a(16'd1001, 1'b0);
      if (i < 2) begin
        repeat (2) begin
          tick();
          chk("t3_stall_valid", 32'(bus_a.out_valid), 0);
          chk("t3_stall_acc", 32'(bus_a.acc_out), 32'(1001 * (i + 1)));
        end
      end
    end
    chk("t3_valid", 32'(bus_a.out_valid), 1);
    chk("t3_acc", 32'(bus_a.acc_out), 3003);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", 32'(bus_a.out_valid), 1);
      chk("t3_hold_acc", 32'(bus_a.acc_out), 3003);
    end
    finish_a();
    chk("t3_idle_valid", 32'(bus_a.out_valid), 0);
    chk("t3_idle_busy", 32'(bus_a.busy), 0);
    chk("t3_idle_acc", 32'(bus_a.acc_out), 3003);
    $display("stall run: acc=%0d", bus_a.acc_out);

    // Zero-count run goes straight to DONE with a cleared total
    start_a(0);
    chk("t4_valid", 32'(bus_a.out_valid), 1);
    chk("t4_acc", 32'(bus_a.acc_out), 0);
    chk("t4_ovf", 32'(bus_a.overflow), 0);
    $display("zero run: acc=%0d", bus_a.acc_out);
    finish_a();

    // Start during ACCUM is ignored
    start_a(2);
    feed_a(16'd100, 1'b0);
    bus_a.num_samples = 8'd5;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    chk("t5_busy", 32'(bus_a.busy), 1);
    chk("t5_acc", 32'(bus_a.acc_out), 100);
    feed_a(16'd200, 1'b0);
    chk("t5_valid", 32'(bus_a.out_valid), 1);
    chk("t5_total", 32'(bus_a.acc_out), 300);
    $display("ignored start run: acc=%0d", bus_a.acc_out);
    finish_a();

    // Overflow on the 17-bit instance
    bus_b.num_samples = 8'd2;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    feed_b(16'd65535, 1'b1);
    chk("t6_mid_acc", 32'(bus_b.acc_out), 131071);
    chk("t6_mid_ovf", 32'(bus_b.overflow), 0);
    feed_b(16'd65535, 1'b1);
    chk("t6_valid", 32'(bus_b.out_valid), 1);
    chk("t6_ovf", 32'(bus_b.overflow), 1);
    chk("t6_acc", 32'(bus_b.acc_out), OVF_EXP);
    $display("overflow run: acc=%0d ovf=%0d", bus_b.acc_out, bus_b.overflow);
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    // Next start clears the sticky flag
    bus_b.num_samples = 8'd1;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    chk("t6_clr_ovf", 32'(bus_b.overflow), 0);
    feed_b(16'd5, 1'b0);
    chk("t6_clr_acc", 32'(bus_b.acc_out), 5);
    $display("post-overflow run: acc=%0d ovf=%0d", bus_b.acc_out, bus_b.overflow);
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;

    // Asynchronous reset mid-run, then a fresh run
    start_a(4);
    feed_a(16'd9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_acc", 32'(bus_a.acc_out), 0);
    chk("t7_rst_busy", 32'(bus_a.busy), 0);
    chk("t7_rst_in_ready", 32'(bus_a.in_ready), 0);
    chk("t7_rst_valid", 32'(bus_a.out_valid), 0);
    chk("t7_rst_ovf", 32'(bus_a.overflow), 0);
    #3 rst_n = 1'b1;
    tick();
    start_a(2);
    feed_a(16'd7, 1'b0);
    feed_a(16'd8, 1'b0);
    chk("t7_valid", 32'(bus_a.out_valid), 1);
    chk("t7_acc", 32'(bus_a.acc_out), 15);
    $display("post-reset run: acc=%0d", bus_a.acc_out);
    finish_a();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
